div_unit: RTL and testbench

Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU in the execute stage. It accepts operands from the E-stage register file/forwarding muxes and produces the 64-bit {HI, LO} result for the HI/LO write path. It drives `stall_divE` into the hazard unit, which holds F through W while the division is in flight.

---
 rtl/div_pkg.sv | 6 +
 rtl/div_unit_if.sv | 20 ++
 rtl/div_step.sv | 20 ++
 rtl/div_unit.sv | 120 ++++++++++++
 tb/tb_div_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the restoring divider
package div_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    localparam int DIV_CYCLES = 32;
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFFFFFF;
endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: E-stage divide request/response bundle between pipeline and divider
interface div_unit_if #(parameter int WIDTH = 32);
    logic               div_en;
    logic               signed_div;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               hold;
    logic               flush;
    logic               stall_divE;
    logic               div_valid;
    logic [2*WIDTH-1:0] div_result;
    modport master (
        output div_en, signed_div, opa, opb, hold, flush,
        input  stall_divE, div_valid, div_result
    );
    modport slave (
        input  div_en, signed_div, opa, opb, hold, flush,
        output stall_divE, div_valid, div_result
    );
endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring iteration (shift {rem,quo} left, trial-subtract divisor)
module div_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;
    logic             unused_top;
    assign shifted    = {rem_i, quo_i[WIDTH-1]};
    assign diff       = {1'b0, shifted} - {2'b00, dvs_i};
    assign borrow     = diff[WIDTH+1];
    // the top bits are zero whenever their half of the mux is selected
    assign unused_top = shifted[WIDTH] ^ diff[WIDTH];
    assign rem_o      = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o      = {quo_i[WIDTH-2:0], ~borrow};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring DIV/DIVU; `DIV_SHORTCUT_EN enables the early-out for trivial quotients
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         resetn,
    div_unit_if.slave   bus
);
    localparam int CW = $clog2(DIV_CYCLES) + 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, opa_q, opa_d;
    logic               sq_q, sq_d, sr_q, sr_d, zero_q, zero_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0]   rem_n, quo_n, abs_a, abs_b, q_fix, r_fix, zero_lo;
    logic               sa, sb, start, short_cut, opb_zero;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    assign sa       = bus.signed_div & bus.opa[WIDTH-1];
    assign sb       = bus.signed_div & bus.opb[WIDTH-1];
    assign abs_a    = sa ? -bus.opa : bus.opa;
    assign abs_b    = sb ? -bus.opb : bus.opb;
    assign opb_zero = bus.opb == '0;
    assign start    = bus.div_en & ~bus.flush;
    assign q_fix    = sq_q ? -quo_n : quo_n;
    assign r_fix    = sr_q ? -rem_n : rem_n;
    assign zero_lo  = WIDTH'(DIV_ZERO_LO);

`ifdef DIV_SHORTCUT_EN
    assign short_cut = opb_zero | (abs_a < abs_b);
`else
    assign short_cut = 1'b0;
`endif

    // state and datapath registers; async reset clears the result so outputs drop at once
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            opa_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            opa_q   <= opa_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // next-state: latch |operands| at start, iterate DIV_CYCLES times, sign-fix into the result
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        opa_d   = opa_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        zero_d  = zero_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.div_en) begin
                    rem_d   = '0;
                    quo_d   = abs_a;
                    dvs_d   = abs_b;
                    opa_d   = bus.opa;
                    sq_d    = sa ^ sb;
                    sr_d    = sa;
                    zero_d  = opb_zero;
                    cnt_d   = '0;
                    state_d = short_cut ? DONE : BUSY;
                    if (short_cut)
                        res_d = opb_zero ? {bus.opa, zero_lo} : {bus.opa, {WIDTH{1'b0}}};
                end
                BUSY: begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                        // signed divide-by-zero would otherwise negate the all-ones quotient
                        res_d   = zero_q ? {opa_q, zero_lo} : {r_fix, q_fix};
                        state_d = DONE;
                    end
                end
                DONE: if (!bus.hold) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.stall_divE = resetn & start & (state_q != DONE);
    assign bus.div_valid  = state_q == DONE;
    assign bus.div_result = res_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an arithmetic reference model
module tb_div_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        if (b == 0) return {a, 32'hFFFFFFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    endfunction

    function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] aa, ab;
        aa = (sgn && a[31]) ? -a : a;
        ab = (sgn && b[31]) ? -b : b;
`ifdef DIV_SHORTCUT_EN
        if (b == 0 || aa < ab) return 1;
`endif
        return (aa == ab) ? 33 : 33;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b, input int hold_n, input string tag);
        logic [63:0] exp;
        int lat, n, lowst;
        exp = model(sgn, a, b);
        lat = exp_lat(sgn, a, b);
        @(negedge clk);
        bus.div_en = 1'b1;
        bus.signed_div = sgn;
        bus.opa = a;
        bus.opb = b;
        #1 chk({tag, "/stall_start"}, bus.stall_divE, 1);
        n = 0;
        lowst = 0;
        while (!bus.div_valid && n < 100) begin
            @(negedge clk);
            n++;
            bus.opa = $urandom;
            bus.opb = $urandom;
            bus.signed_div = ~sgn;
            if (!bus.div_valid && !bus.stall_divE) lowst++;
        end
        chk({tag, "/latency"}, n, lat);
        chk({tag, "/stall_busy"}, lowst, 0);
        chk({tag, "/stall_done"}, bus.stall_divE, 0);
        chk({tag, "/result"}, bus.div_result, exp);
        if (hold_n > 0) begin
            bus.hold = 1'b1;
            repeat (hold_n) begin
                @(negedge clk);
                chk({tag, "/hold_valid"}, bus.div_valid, 1);
                chk({tag, "/hold_result"}, bus.div_result, exp);
                chk({tag, "/hold_stall"}, bus.stall_divE, 0);
            end
            bus.hold = 1'b0;
        end
        bus.div_en = 1'b0;
        @(negedge clk);
        chk({tag, "/idle_after"}, bus.div_valid, 0);
    endtask

    initial begin
        int seen;
        bus.div_en = 1'b0;
        bus.signed_div = 1'b0;
        bus.opa = '0;
        bus.opb = '0;
        bus.hold = 1'b0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset/valid", bus.div_valid, 0);
        chk("reset/stall", bus.stall_divE, 0);
        chk("reset/result", bus.div_result, 0);
        resetn = 1'b1;
        @(negedge clk);

        run(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
        run(1'b1, 32'hFFFFFFF9, 32'd2, 0, "div_m7_2");
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "div_ovf");
        run(1'b0, 32'd5, 32'd0, 0, "divu_5_0");
        run(1'b1, 32'hFFFFFFF0, 32'd0, 0, "div_neg_0");
        run(1'b0, 32'd3, 32'd10, 0, "divu_3_10");
        run(1'b1, 32'hFFFFFFFD, 32'd10, 0, "div_m3_10");
        run(1'b0, 32'd1000, 32'd13, 4, "hold");

        // flush mid-division: stall drops at once and no result ever appears
        @(negedge clk);
        bus.div_en = 1'b1;
        bus.signed_div = 1'b1;
        bus.opa = 32'd1234567;
        bus.opb = 32'hFFFFFFF5;
        repeat (15) @(negedge clk);
        bus.flush = 1'b1;
        #1 chk("flush/stall", bus.stall_divE, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.div_en = 1'b0;
        chk("flush/valid", bus.div_valid, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.div_valid) seen++;
        end
        chk("flush/never_valid", seen, 0);
        run(1'b0, 32'd9, 32'd3, 0, "after_flush");

        // flush and div_en together in IDLE: nothing starts
        @(negedge clk);
        bus.div_en = 1'b1;
        bus.flush = 1'b1;
        bus.opa = 32'd50;
        bus.opb = 32'd5;
        #1 chk("flush_start/stall", bus.stall_divE, 0);
        @(negedge clk);
        bus.div_en = 1'b0;
        bus.flush = 1'b0;
        chk("flush_start/valid", bus.div_valid, 0);
        run(1'b0, 32'd50, 32'd5, 0, "after_flush_start");

        // asynchronous reset mid-division
        @(negedge clk);
        bus.div_en = 1'b1;
        bus.signed_div = 1'b0;
        bus.opa = 32'd1000;
        bus.opb = 32'd3;
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("rst_mid/stall", bus.stall_divE, 0);
        chk("rst_mid/valid", bus.div_valid, 0);
        chk("rst_mid/result", bus.div_result, 0);
        bus.div_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_rel/valid", bus.div_valid, 0);
        chk("rst_rel/stall", bus.stall_divE, 0);
        run(1'b1, 32'h7FFFFFFF, 32'h80000000, 0, "after_reset");

        // randomized operands with biased divisor classes
        for (int i = 0; i < 40; i++) begin
            logic        sgn;
            logic [31:0] a, b;
            int          m;
            sgn = 1'($urandom_range(0, 1));
            a = $urandom;
            m = $urandom_range(0, 9);
            if (m == 0) b = 0;
            else if (m <= 3) b = $urandom_range(1, 15);
            else if (m == 4) b = 32'hFFFFFFFF;
            else if (m == 5) b = -($urandom_range(1, 15));
            else b = $urandom;
            if ($urandom_range(0, 4) == 0) a = $urandom_range(0, 20);
            run(sgn, a, b, $urandom_range(0, 2), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
